voltin: RTL and testbench



---
 rtl/voltin_pkg.sv | 17 +
 rtl/voltin_cla4.sv | 48 ++++
 rtl/voltin.sv | 61 ++++++
 tb/tb_voltin.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/voltin_pkg.sv
// ============================================================================
// Module  : voltin_pkg
// Brief   : Shared widths and word type for the voltin adder datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package voltin_pkg;

   localparam int VOLTIN_WIDTH = 32;
   localparam int VOLTIN_GROUP = 4;

   typedef logic [VOLTIN_WIDTH-1:0] voltin_word_t;

endpackage : voltin_pkg

`default_nettype wire

// File: rtl/voltin_cla4.sv
// ============================================================================
// Module  : voltin_cla4
// Brief   : 4-bit carry-lookahead group producing sum, group generate/propagate.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module voltin_cla4
   import voltin_pkg::*;
(
   input  logic [VOLTIN_GROUP-1:0] a,
   input  logic [VOLTIN_GROUP-1:0] b,
   input  logic                    cin,
   output logic [VOLTIN_GROUP-1:0] sum,
   output logic                    gg,
   output logic                    gp
);

   logic [VOLTIN_GROUP-1:0] w_g;
   logic [VOLTIN_GROUP-1:0] w_p;
   logic [VOLTIN_GROUP-1:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Every internal carry is a flat sum of products of cin and bit g/p terms.
   assign w_c[0] = cin;
   assign w_c[1] = w_g[0]
                 | (w_p[0] & cin);
   assign w_c[2] = w_g[1]
                 | (w_p[1] & w_g[0])
                 | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2]
                 | (w_p[2] & w_g[1])
                 | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);

   assign gg = w_g[3]
             | (w_p[3] & w_g[2])
             | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign gp = &w_p;

   assign sum = w_p ^ w_c;

endmodule : voltin_cla4

`default_nettype wire

// File: rtl/voltin.sv
// ============================================================================
// Module  : voltin
// Brief   : Registered WIDTH-bit adder (a + b + cin) built from CLA4 groups.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module voltin
   import voltin_pkg::*;
#(
   parameter int WIDTH = VOLTIN_WIDTH
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] finout,
   output logic             cout
);

   localparam int C_NGROUPS = WIDTH / VOLTIN_GROUP;

   logic [C_NGROUPS:0]  w_carry;
   logic [C_NGROUPS-1:0] w_gg;
   logic [C_NGROUPS-1:0] w_gp;
   logic [WIDTH-1:0]    w_sum;
   logic [WIDTH-1:0]    r_finout;
   logic                r_cout;

   assign w_carry[0] = cin;

   // Lookahead inside each group; carries ripple between groups.
   for (genvar k = 0; k < C_NGROUPS; k++) begin : g_grp
      voltin_cla4 u_cla4 (
         .a   (a[k*VOLTIN_GROUP +: VOLTIN_GROUP]),
         .b   (b[k*VOLTIN_GROUP +: VOLTIN_GROUP]),
         .cin (w_carry[k]),
         .sum (w_sum[k*VOLTIN_GROUP +: VOLTIN_GROUP]),
         .gg  (w_gg[k]),
         .gp  (w_gp[k])
      );
      assign w_carry[k+1] = w_gg[k] | (w_gp[k] & w_carry[k]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_finout <= '0;
         r_cout   <= 1'b0;
      end else begin
         r_finout <= w_sum;
         r_cout   <= w_carry[C_NGROUPS];
      end
   end

   assign finout = r_finout;
   assign cout   = r_cout;

endmodule : voltin

`default_nettype wire

// File: tb/tb_voltin.sv
// ============================================================================
// Module  : tb_voltin
// Brief   : Self-checking bench for voltin: directed table, reset and random.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voltin;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [W-1:0] finout;
   logic         cout;

   int checks;
   int errors;

   voltin #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .finout (finout),
      .cout   (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got {cout,finout}=%h expected %h", name, got, exp);
      end
   endtask

   // Drive operands, clock once, then compare the registered result.
   task automatic apply(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic [W:0] exp);
      a   = va;
      b   = vb;
      cin = vc;
      @(posedge clk);
      #1;
      check(name, {cout, finout}, exp);
   endtask

   vec_t vecs [13];

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic [W:0]   ref_sum;

      checks = 0;
      errors = 0;

      vecs[0]  = '{32'h0000_0001, 32'h0000_0005, 1'b0, 32'h0000_0006, 1'b0};
      vecs[1]  = '{32'h0000_0002, 32'h0000_0006, 1'b0, 32'h0000_0008, 1'b0};
      vecs[2]  = '{32'h0000_0003, 32'h0000_0007, 1'b0, 32'h0000_000A, 1'b0};
      vecs[3]  = '{32'h0000_0004, 32'h0000_0008, 1'b0, 32'h0000_000C, 1'b0};
      vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
      vecs[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
      vecs[6]  = '{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0};
      vecs[7]  = '{32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0};
      vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
      vecs[9]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0};
      vecs[10] = '{32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0};
      vecs[11] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};
      vecs[12] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};

      // Reset held low with live operands: outputs stay zero across edges.
      rst_n = 1'b0;
      a     = 32'h1234_5678;
      b     = 32'h0000_0001;
      cin   = 1'b0;
      #1;
      check("reset_async", {cout, finout}, 33'h0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", {cout, finout}, 33'h0);

      // Release between edges; the first edge high captures the inputs.
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_release", {cout, finout}, 33'h0_1234_5679);

      // Back-to-back table: operands change every cycle.
      for (int i = 0; i < 13; i++) begin
         apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
               {vecs[i].exp_cout, vecs[i].exp_sum});
      end

      // Mid-run reset pulse clears outputs without a clock edge.
      apply("pre_pulse", 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 33'h1_0000_0001);
      #2;
      rst_n = 1'b0;
      #1;
      check("pulse_async_clear", {cout, finout}, 33'h0);
      a = 32'hDEAD_BEEF;
      b = 32'hFFFF_0000;
      @(posedge clk);
      #1;
      check("pulse_hold", {cout, finout}, 33'h0);
      rst_n = 1'b1;
      apply("post_pulse", 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b0, 33'h1_DEAC_BEEF);

      // Random operands against a 33-bit reference sum.
      for (int i = 0; i < 10000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         ref_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         apply("random", ra, rb, rc, ref_sum);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_voltin

`default_nettype wire
